// File: rtl/cle_seq_lock.sv
// cle_seq_lock: knock-sequence unlock on bus reads, then LFSR challenge response per read.
// Optional idle relock timeout is built when CLE_SEQ_LOCK_TIMEOUT_EN is defined.
module cle_seq_lock #(
  parameter int unsigned ADDR_W = 14,
  parameter logic [ADDR_W-1:0] WIN_MASK = 14'h3000,
  parameter logic [ADDR_W-1:0] WIN_BASE = 14'h1000,
  parameter int unsigned KEY_LSB = 4,
  parameter int unsigned KEY_W = 4,
  parameter int unsigned SEQ_LEN = 4,
  parameter logic [SEQ_LEN*KEY_W-1:0] SEQ_PATTERN = 16'h8A92,
  parameter int unsigned LFSR_W = 6,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 6'b100001,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 6'h01,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_stb,
  input  logic              sser,
  input  logic [ADDR_W-1:0] ba,
  input  logic              br_w,
  output logic              resp_oe,
  output logic              resp_bit,
  output logic              unlocked,
  output logic [3:0]        seq_idx
);

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  typedef enum logic [0:0] {ST_SEEK = 1'b0, ST_UNLOCKED = 1'b1} state_t;

  state_t              state, state_d;
  logic [IDX_W-1:0]    idx_d;
  logic [LFSR_W-1:0]   lfsr, lfsr_d;
  logic                resp_oe_d, resp_bit_d;
  logic                hit, rd_hit, wr_hit, relock;
  logic [KEY_W-1:0]    key;

  function automatic logic [KEY_W-1:0] key_at(input logic [IDX_W-1:0] idx);
    return KEY_W'(SEQ_PATTERN >> (KEY_W * 32'(idx)));
  endfunction

  assign hit    = acc_stb & ~sser & ((ba & WIN_MASK) == WIN_BASE);
  assign rd_hit = hit & br_w;
  assign wr_hit = hit & ~br_w;
  assign key    = ba[KEY_LSB +: KEY_W];

`ifdef CLE_SEQ_LOCK_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;

  // Idle counter saturates; only a hit can leave the idle state, and a hit clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (hit) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign relock = (to_cnt == TO_MAX) && ((state != ST_SEEK) || (seq_idx != '0));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign relock = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_SEEK;
      seq_idx  <= '0;
      lfsr     <= LFSR_SEED;
      resp_oe  <= 1'b0;
      resp_bit <= 1'b0;
      unlocked <= 1'b0;
    end else begin
      state    <= state_d;
      seq_idx  <= idx_d;
      lfsr     <= lfsr_d;
      resp_oe  <= resp_oe_d;
      resp_bit <= resp_bit_d;
      unlocked <= (state_d == ST_UNLOCKED);
    end
  end

  // Next state: writes always relock; a hit outranks the idle timeout.
  always_comb begin
    state_d = state;
    idx_d   = seq_idx;
    if (wr_hit) begin
      state_d = ST_SEEK;
      idx_d   = '0;
    end else if (rd_hit) begin
      if (state == ST_UNLOCKED) begin
        idx_d = '0;
        if (key != key_at(LAST_IDX)) begin
          state_d = ST_SEEK;
        end
      end else if (key == key_at(seq_idx)) begin
        if (seq_idx == LAST_IDX) begin
          state_d = ST_UNLOCKED;
          idx_d   = '0;
        end else begin
          idx_d = seq_idx + IDX_W'(1);
        end
      end else begin
        idx_d = (key == key_at('0)) ? IDX_W'(1) : '0;
      end
    end else if (relock) begin
      state_d = ST_SEEK;
      idx_d   = '0;
    end
  end

  // Outputs and response generator
  always_comb begin
    lfsr_d     = lfsr;
    resp_oe_d  = 1'b0;
    resp_bit_d = resp_bit;
    if (rd_hit && (state == ST_UNLOCKED)) begin
      resp_oe_d  = 1'b1;
      resp_bit_d = lfsr[LFSR_W-1];
      lfsr_d     = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end else if (rd_hit && (state_d == ST_UNLOCKED)) begin
      lfsr_d = LFSR_SEED;
    end
  end

endmodule

// File: tb/tb_cle_seq_lock.sv
// Self-checking bench for cle_seq_lock: directed scenarios plus random bus traffic vs. a behavioural model.
module tb_cle_seq_lock;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_stb;
  logic        sser;
  logic [13:0] ba;
  logic        br_w;
  logic        resp_oe;
  logic        resp_bit;
  logic        unlocked;
  logic [3:0]  seq_idx;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int keys[4] = '{2, 9, 10, 8};
  bit m_unl;
  int m_idx;
  int m_lfsr;
  bit m_oe;
  bit m_bit;
  int m_idle;

  always #5 clk = ~clk;

  cle_seq_lock #(.TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .acc_stb  (acc_stb),
    .sser     (sser),
    .ba       (ba),
    .br_w     (br_w),
    .resp_oe  (resp_oe),
    .resp_bit (resp_bit),
    .unlocked (unlocked),
    .seq_idx  (seq_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_unl  = 1'b0;
    m_idx  = 0;
    m_lfsr = 1;
    m_oe   = 1'b0;
    m_bit  = 1'b0;
    m_idle = 0;
  endtask

  task automatic model_step(input bit acc, input bit ss, input logic [13:0] addr, input bit rw);
    bit hit;
    int key;
    hit  = acc && !ss && ((addr & 14'h3000) == 14'h1000);
    key  = (int'(addr) >> 4) & 15;
    m_oe = 1'b0;
    if (hit) begin
      m_idle = 0;
      if (!rw) begin
        m_unl = 1'b0;
        m_idx = 0;
      end else if (m_unl) begin
        m_oe   = 1'b1;
        m_bit  = ((m_lfsr >> 5) & 1) != 0;
        m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 5) ^ m_lfsr) & 1)) & 63;
        if (key != keys[3]) begin
          m_unl = 1'b0;
          m_idx = 0;
        end
      end else if (key == keys[m_idx]) begin
        if (m_idx == 3) begin
          m_unl  = 1'b1;
          m_idx  = 0;
          m_lfsr = 1;
        end else begin
          m_idx++;
        end
      end else begin
        m_idx = (key == keys[0]) ? 1 : 0;
      end
    end else begin
`ifdef CLE_SEQ_LOCK_TIMEOUT_EN
      m_idle++;
      if (m_idle >= TO && (m_unl || m_idx != 0)) begin
        m_unl = 1'b0;
        m_idx = 0;
      end
`endif
    end
  endtask

  // One bus cycle: drive at negedge, let the edge happen, compare all outputs just after it.
  task automatic cyc(input bit acc, input bit ss, input logic [13:0] addr, input bit rw, input string tag);
    @(negedge clk);
    acc_stb = acc;
    sser    = ss;
    ba      = addr;
    br_w    = rw;
    @(posedge clk);
    model_step(acc, ss, addr, rw);
    #1;
    check({tag, ".unlocked"}, 32'(unlocked), 32'(m_unl));
    check({tag, ".seq_idx"},  32'(seq_idx),  32'(m_idx));
    check({tag, ".resp_oe"},  32'(resp_oe),  32'(m_oe));
    check({tag, ".resp_bit"}, 32'(resp_bit), 32'(m_bit));
  endtask

  task automatic rd(input logic [13:0] addr, input string tag);
    cyc(1'b1, 1'b0, addr, 1'b1, tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 14'h1020, 1'b1, tag);
  endtask

  task automatic unlock_seq(input string tag);
    rd(14'h1020, tag);
    rd(14'h1090, tag);
    rd(14'h10A0, tag);
    rd(14'h1080, tag);
  endtask

  initial begin
    bit exp_bits[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [13:0] addr;

    rst = 1'b1; acc_stb = 1'b0; sser = 1'b1; ba = '0; br_w = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("reset.unlocked", 32'(unlocked), 32'd0);
    check("reset.seq_idx",  32'(seq_idx),  32'd0);
    check("reset.resp_oe",  32'(resp_oe),  32'd0);
    check("reset.resp_bit", 32'(resp_bit), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic unlock with seq_idx progression
    rd(14'h1020, "unlk1"); check("unlk1.idx", 32'(seq_idx), 32'd1);
    rd(14'h1090, "unlk2"); check("unlk2.idx", 32'(seq_idx), 32'd2);
    rd(14'h10A0, "unlk3"); check("unlk3.idx", 32'(seq_idx), 32'd3);
    rd(14'h1080, "unlk4"); check("unlk4.idx", 32'(seq_idx), 32'd0);
    check("unlk4.state", 32'(unlocked), 32'd1);

    // Response stream from the seeded generator
    for (int i = 0; i < 6; i++) begin
      rd(14'h1080, "resp");
      check("resp.oe_const", 32'(resp_oe), 32'd1);
      check("resp.bit_const", 32'(resp_bit), 32'(exp_bits[i]));
    end
    idle("resp_idle");
    check("resp_idle.oe", 32'(resp_oe), 32'd0);

    // Write hit relocks without a response
    cyc(1'b1, 1'b0, 14'h1080, 1'b0, "wr");
    check("wr.unlocked", 32'(unlocked), 32'd0);
    check("wr.oe", 32'(resp_oe), 32'd0);

    // Restart on repeated first key
    rd(14'h1020, "rst2a");
    rd(14'h1090, "rst2b");
    rd(14'h1020, "rst2c"); check("restart.idx", 32'(seq_idx), 32'd1);
    rd(14'h1090, "rst2d");
    rd(14'h10A0, "rst2e");
    rd(14'h1080, "rst2f"); check("restart.unl", 32'(unlocked), 32'd1);

    // Wrong key while unlocked: one response, then relock
    rd(14'h1050, "badkey");
    check("badkey.oe", 32'(resp_oe), 32'd1);
    check("badkey.unl", 32'(unlocked), 32'd0);

    // Out-of-window and deselected accesses are ignored
    rd(14'h1020, "win1");
    rd(14'h1090, "win2");
    rd(14'h3020, "win_out"); check("win_out.idx", 32'(seq_idx), 32'd2);
    cyc(1'b1, 1'b1, 14'h1000, 1'b1, "sser_hi"); check("sser_hi.idx", 32'(seq_idx), 32'd2);
    cyc(1'b0, 1'b0, 14'h1000, 1'b1, "no_stb"); check("no_stb.idx", 32'(seq_idx), 32'd2);

    // Idle relock behaviour
    for (int i = 0; i < 8; i++) idle("to_idle");
`ifdef CLE_SEQ_LOCK_TIMEOUT_EN
    check("timeout.idx", 32'(seq_idx), 32'd0);
`else
    check("timeout.idx", 32'(seq_idx), 32'd2);
`endif

    // Reset during a pending response suppresses the pulse
    cyc(1'b1, 1'b0, 14'h1000, 1'b0, "pre_rst");
    unlock_seq("pre_rst");
    @(negedge clk);
    acc_stb = 1'b1; sser = 1'b0; ba = 14'h1080; br_w = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst.unlocked", 32'(unlocked), 32'd0);
    @(posedge clk); #1;
    check("async_rst.oe", 32'(resp_oe), 32'd0);
    check("async_rst.idx", 32'(seq_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0; acc_stb = 1'b0;
    model_reset();
    rd(14'h1020, "post_rst"); check("post_rst.idx", 32'(seq_idx), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) unlock_seq("rnd_unlk");
      if (i % 137 == 0) begin
        for (int j = 0; j < 10; j++) idle("rnd_idle");
      end
      addr = 14'($urandom);
      if ($urandom_range(0, 99) < 85) addr = (addr & ~14'h3000) | 14'h1000;
      if ($urandom_range(0, 9) < 7) addr[7:4] = 4'(keys[$urandom_range(0, 3)]);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, addr,
          $urandom_range(0, 19) != 0, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
